// File: rtl/fixed_mac_sat_ctrl.sv
// Q8.8 multiply-accumulate sequencer: accumulates len products into a Q56.8 register, then saturates to Q8.8.
// Optional MAC_ROUND_EN: round each product half toward +inf before scaling instead of truncating.
module fixed_mac_sat_ctrl #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      a_in,
    input  logic [15:0]      b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      result,
    output logic             overflow,
    output logic             underflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        CLAMP = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t state, state_next;

    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   count;
    logic [63:0]        acc;
    logic signed [31:0] prod;
    logic signed [32:0] prod_adj;
    logic signed [32:0] prod_shr;
    logic [63:0]        term;
    logic               accept;
    logic               last_term;

    // Q16.16 product, optionally biased by half an LSB of Q.8, then scaled to Q.8
    assign prod = $signed(a_in) * $signed(b_in);
`ifdef MAC_ROUND_EN
    assign prod_adj = {prod[31], prod} + 33'sd128;
`else
    assign prod_adj = {prod[31], prod};
`endif
    assign prod_shr  = prod_adj >>> 8;
    assign term      = {{31{prod_shr[32]}}, prod_shr};

    assign accept    = in_valid && in_ready;
    assign last_term = (count + LEN_W'(1)) == len_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = (len != '0) ? ACCUM : CLAMP;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (accept && last_term) state_next = CLAMP;
            end
            CLAMP: state_next = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Accumulator wraps mod 2^64; saturation happens only once, in CLAMP
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q     <= '0;
            count     <= '0;
            acc       <= '0;
            result    <= 16'h0000;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q <= len;
                        count <= '0;
                        acc   <= '0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc   <= acc + term;
                        count <= count + LEN_W'(1);
                    end
                end
                CLAMP: begin
                    if ($signed(acc) > 64'sd32767) begin
                        result    <= 16'h7FFF;
                        overflow  <= 1'b1;
                        underflow <= 1'b0;
                    end else if ($signed(acc) < -64'sd32768) begin
                        result    <= 16'h8000;
                        overflow  <= 1'b0;
                        underflow <= 1'b1;
                    end else begin
                        result    <= acc[15:0];
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_mac_sat_ctrl.sv
// Randomized self-checking bench for fixed_mac_sat_ctrl against an arithmetic reference model.
// Build with +define+MAC_ROUND_EN to check the rounding variant.
module tb_fixed_mac_sat_ctrl;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      a_in;
    logic [15:0]      b_in;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      result;
    logic             overflow;
    logic             underflow;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];

    fixed_mac_sat_ctrl #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: exact integer products, floor-divided by 256, summed, then saturated
    function automatic logic [17:0] model(input int n);
        longint sum = 0;
        longint p;
        longint q;
        for (int i = 0; i < n; i++) begin
            p = longint'($signed(qa[i])) * longint'($signed(qb[i]));
`ifdef MAC_ROUND_EN
            p = p + 128;
`endif
            q = p / 256;
            if (p < 0 && (p % 256) != 0) q = q - 1;
            sum = sum + q;
        end
        if (sum > 32767)       return {2'b10, 16'h7FFF};
        else if (sum < -32768) return {2'b01, 16'h8000};
        else                   return {2'b00, 16'(sum)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one complete transaction using the pairs queued in qa/qb
    task automatic applyStimulus(input int n, input int hold, input int gap_pct);
        logic [17:0] exp;
        logic        accepted;
        int          idx = 0;
        int          cyc = 0;
        exp = model(n);
        start = 1'b1;
        len   = LEN_W'(n);
        tick();
        start = 1'b0;
        checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
        checkOutput("in_ready_after_start", {31'd0, in_ready}, (n != 0) ? 32'd1 : 32'd0);
        while (idx < n && cyc < 2000) begin
            if ($urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                a_in     = qa[idx];
                b_in     = qb[idx];
            end
            accepted = in_valid && in_ready;
            tick();
            if (accepted) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        if (idx < n) checkOutput("accept_timeout", idx, n);
        checkOutput("clamp_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("clamp_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        checkOutput("out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("result", {16'd0, result}, {16'd0, exp[15:0]});
        checkOutput("flags", {30'd0, overflow, underflow}, {30'd0, exp[17:16]});
        for (int k = 0; k < hold; k++) begin
            start = 1'($urandom_range(0, 1));
            len   = LEN_W'($urandom_range(0, 5));
            tick();
            checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("hold_result", {14'd0, overflow, underflow, result}, {14'd0, exp});
        end
        start     = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("post_hs_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("post_hs_busy", {31'd0, busy}, 32'd0);
        checkOutput("kept_result", {14'd0, overflow, underflow, result}, {14'd0, exp});
    endtask

    task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
        qa.push_back(a);
        qb.push_back(b);
    endtask

    function automatic logic [15:0] rand_operand();
        if ($urandom_range(0, 2) == 0) return 16'($urandom);
        return 16'($urandom_range(0, 16'h0C00)) - 16'h0600;
    endfunction

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        out_ready = 1'b0;
        repeat (2) tick();
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_result", {14'd0, overflow, underflow, result}, 32'd0);
        rst = 1'b0;
        tick();

        qa.delete(); qb.delete();
        push_pair(16'h0100, 16'h0200);
        push_pair(16'h0080, 16'h0400);
        push_pair(16'hFF00, 16'h0180);
        applyStimulus(3, 0, 0);
        checkOutput("basic_literal", {16'd0, result}, 32'h0280);

        qa.delete(); qb.delete();
        push_pair(16'h0100, 16'h0200);
        push_pair(16'h0080, 16'h0400);
        push_pair(16'hFF00, 16'h0180);
        applyStimulus(3, 5, 60);

        qa.delete(); qb.delete();
        push_pair(16'h6400, 16'h6400);
        push_pair(16'h6400, 16'h6400);
        applyStimulus(2, 1, 0);
        checkOutput("ovf_literal", {14'd0, overflow, underflow, result}, {14'd0, 2'b10, 16'h7FFF});

        qa.delete(); qb.delete();
        push_pair(16'h8000, 16'h7FFF);
        applyStimulus(1, 0, 0);
        checkOutput("udf_literal", {14'd0, overflow, underflow, result}, {14'd0, 2'b01, 16'h8000});

        qa.delete(); qb.delete();
        applyStimulus(0, 2, 0);
        checkOutput("len0_literal", {14'd0, overflow, underflow, result}, 32'd0);

        qa.delete(); qb.delete();
        push_pair(16'h0001, 16'h0080);
        applyStimulus(1, 0, 0);
`ifdef MAC_ROUND_EN
        checkOutput("round_literal", {16'd0, result}, 32'h0001);
`else
        checkOutput("round_literal", {16'd0, result}, 32'h0000);
`endif

        // Reset in the middle of accumulation discards the partial sum
        start = 1'b1;
        len   = LEN_W'(3);
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        a_in     = 16'h7000;
        b_in     = 16'h7000;
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        qa.delete(); qb.delete();
        push_pair(16'h0200, 16'h0300);
        push_pair(16'hFE00, 16'h0100);
        applyStimulus(2, 0, 30);
        checkOutput("midrst_fresh", {16'd0, result}, 32'h0400);

        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(1, 7);
            qa.delete(); qb.delete();
            for (int i = 0; i < n; i++) push_pair(rand_operand(), rand_operand());
            applyStimulus(n, $urandom_range(0, 3), $urandom_range(0, 50));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
